// File: rtl/instruction_stage_sequencer.sv
// Multi-cycle instruction stage sequencer: fetch/decode/execute/memory/reg-update/pc-update FSM
// with a memory-wait timeout trap, a debug halt and an optional retired-instruction counter (INSTRET_COUNTER_EN).
module instruction_stage_sequencer #(
  parameter logic [15:0] MEM_TIMEOUT   = 16'd1024,
  parameter int          TIMEOUT_WIDTH = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       illegal_instr,
  input  logic       mem_ready,
  input  logic       halt_req,
  output logic [2:0] stage,
  output logic       mem_req,
  output logic       instr_retired,
  output logic       halted,
  output logic       bus_error
`ifdef INSTRET_COUNTER_EN
  ,
  input  logic        instret_clr,
  output logic [63:0] instret
`endif
);

  typedef enum logic [2:0] {
    FETCH           = 3'd0,
    DECODE          = 3'd1,
    EXECUTE         = 3'd2,
    MEMORY          = 3'd3,
    REGISTER_UPDATE = 3'd4,
    PC_UPDATE       = 3'd5,
    HALTED          = 3'd6,
    TRAP            = 3'd7
  } stage_e;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpOp     = 7'b0110011;
  localparam logic [6:0] OpOpImm  = 7'b0010011;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpSystem = 7'b1110011;

  localparam bit                       TimeoutEn   = (MEM_TIMEOUT != 16'd0);
  localparam logic [TIMEOUT_WIDTH-1:0] TimeoutLast = TIMEOUT_WIDTH'(MEM_TIMEOUT - 16'd1);

  stage_e                   state_q, state_d;
  logic [TIMEOUT_WIDTH-1:0] waitCnt_q, waitCnt_d;
  logic                     busError_q, busError_d;

  // The wait counter only survives while the FSM stays in FETCH/MEMORY; any transition clears it.
  always_comb begin
    state_d    = state_q;
    waitCnt_d  = '0;
    busError_d = busError_q;
    case (state_q)
      FETCH, MEMORY: begin
        if (mem_ready) begin
          if (state_q == FETCH)       state_d = DECODE;
          else if (opcode == OpStore) state_d = PC_UPDATE;
          else                        state_d = REGISTER_UPDATE;
        end else if (TimeoutEn && (waitCnt_q == TimeoutLast)) begin
          state_d    = TRAP;
          busError_d = 1'b1;
        end else begin
          waitCnt_d = waitCnt_q + 1'b1;
        end
      end
      DECODE:          state_d = illegal_instr ? TRAP : EXECUTE;
      EXECUTE: begin
        case (opcode)
          OpLoad, OpStore: state_d = MEMORY;
          OpOp, OpOpImm, OpAuipc, OpLui, OpJal, OpJalr, OpSystem:
                           state_d = REGISTER_UPDATE;
          default:         state_d = PC_UPDATE;
        endcase
      end
      REGISTER_UPDATE: state_d = PC_UPDATE;
      PC_UPDATE:       state_d = halt_req ? HALTED : FETCH;
      HALTED:          state_d = halt_req ? HALTED : FETCH;
      TRAP:            state_d = TRAP;
      default:         state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= FETCH;
      waitCnt_q  <= '0;
      busError_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      waitCnt_q  <= waitCnt_d;
      busError_q <= busError_d;
    end
  end

  assign stage         = state_q;
  assign mem_req       = !reset && ((state_q == FETCH) || (state_q == MEMORY));
  assign instr_retired = (state_q == PC_UPDATE);
  assign halted        = (state_q == HALTED);
  assign bus_error     = busError_q;

`ifdef INSTRET_COUNTER_EN
  logic [63:0] instret_q;

  // Clear wins over a coincident retire.
  always_ff @(posedge clk) begin
    if (reset)              instret_q <= '0;
    else if (instret_clr)   instret_q <= '0;
    else if (instr_retired) instret_q <= instret_q + 64'd1;
  end

  assign instret = instret_q;
`endif

endmodule
